// File: rtl/c3lib_async_fifo_wr_arb.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ requesters, in bursts of up to BURST_MAX words.
// Latency is one cycle from handshake to fifo_wr_en. req_ready drops while the FIFO is partially full or arb_en is low.
module c3lib_async_fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DWIDTH    = 8,
  parameter int BURST_MAX = 4,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [DWIDTH-1:0]         fifo_wr_data,
  input  logic                      fifo_wr_full,
  input  logic                      fifo_wr_pfull,
  output logic                      grant_active,
  output logic [IDW-1:0]            grant_id,
  input  logic                      ovf_clr,
  output logic                      ovf_err
);

  localparam int BCW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(BURST_MAX - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic [DWIDTH-1:0]   fifo_wr_data_q, fifo_wr_data_d;
  logic                ovf_err_q, ovf_err_d;

  logic                sel_found;
  logic [IDW-1:0]      sel_idx;
  logic [IDW-1:0]      cand;
  int                  idx;
  logic                gnt_rdy;
  logic                xfer;
  logic                gnt_valid;
  logic                gnt_last;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_id_q     <= '0;
      bcnt_q         <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      ovf_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      bcnt_q         <= bcnt_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      ovf_err_q      <= ovf_err_d;
    end
  end

  // Ready never looks at req_valid, so a source may derive valid from ready.
  always_comb begin
    grant_active = (state_q == BURST);
    gnt_rdy      = grant_active & arb_en & ~fifo_wr_pfull;
    req_ready    = gnt_rdy ? (NUM_REQ'(1) << grant_id_q) : '0;
    gnt_valid    = req_valid[grant_id_q];
    gnt_last     = req_last[grant_id_q];
    xfer         = gnt_rdy & gnt_valid;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    bcnt_d     = bcnt_q;
    case (state_q)
      IDLE: begin
        if (arb_en && !fifo_wr_pfull && sel_found) begin
          grant_id_d = sel_idx;
          bcnt_d     = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (xfer) bcnt_d = bcnt_q + BCW'(1);
        if ((xfer && (gnt_last || bcnt_q == BCNT_LAST)) || !gnt_valid || !arb_en) begin
          state_d = IDLE;
          ptr_d   = (grant_id_q == ID_LAST) ? '0 : grant_id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Overflow set outranks a same-cycle clear so no event is lost.
  always_comb begin
    fifo_wr_en_d   = xfer;
    fifo_wr_data_d = xfer ? req_data[grant_id_q*DWIDTH +: DWIDTH] : fifo_wr_data_q;
    ovf_err_d      = ovf_err_q;
    if (fifo_wr_en_q && fifo_wr_full) ovf_err_d = 1'b1;
    else if (ovf_clr)                 ovf_err_d = 1'b0;
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign grant_id     = grant_id_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_c3lib_async_fifo_wr_arb.sv
// Bench for c3lib_async_fifo_wr_arb: directed scenarios then random traffic, checked each cycle against a word-counting reference model.
module tb_c3lib_async_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arb_en = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          fifo_wr_full = 1'b0;
  logic          fifo_wr_pfull = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [N-1:0]  req_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          grant_active;
  logic [IW-1:0] grant_id;
  logic          ovf_err;

  c3lib_async_fifo_wr_arb #(.NUM_REQ(N), .DWIDTH(DW), .BURST_MAX(BM), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .fifo_wr_pfull(fifo_wr_pfull),
    .grant_active(grant_active), .grant_id(grant_id),
    .ovf_clr(ovf_clr), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a granted requester, how many words it has sent, and where the next search starts.
  bit            m_busy;
  int            m_gid, m_cnt, m_ptr;
  bit            m_wen;
  logic [DW-1:0] m_wdata;
  bit            m_ovf;

  int  src_w[N];
  int  plen[N];
  bit  dir_mode;

  int            dut_hs[N];
  int            dut_wr;
  logic [DW-1:0] dut_wq[$];
  int            dut_gq[$];
  bit            prev_ga;
  int            stall_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    if (m_busy && arb_en && !fifo_wr_pfull) return N'(1) << m_gid;
    return '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    m_wen = 0; m_wdata = '0; m_ovf = 0;
  endtask

  task automatic model_update();
    logic [N-1:0] rdy;
    bit xfer;
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rdy = exp_ready();
    for (int i = 0; i < N; i++) if (rdy[i] && req_valid[i]) src_w[i]++;
    if (m_wen && fifo_wr_full) m_ovf = 1;
    else if (ovf_clr)          m_ovf = 0;
    if (!m_busy) begin
      m_wen = 0;
      if (arb_en && !fifo_wr_pfull && req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          g = (m_ptr + k) % N;
          if (req_valid[g]) begin
            m_gid = g;
            break;
          end
        end
        m_busy = 1;
        m_cnt  = 0;
      end
    end else begin
      xfer  = rdy[m_gid] && req_valid[m_gid];
      m_wen = xfer;
      if (xfer) begin
        m_wdata = req_data[m_gid*DW +: DW];
        m_cnt++;
      end
      if ((xfer && (req_last[m_gid] || m_cnt == BM)) || !req_valid[m_gid] || !arb_en) begin
        m_busy = 0;
        m_ptr  = (m_gid + 1) % N;
      end
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = {4'(i), 4'(src_w[i])};
      if (plen[i] == 0) req_last[i] = 1'b0;
      else              req_last[i] = ((src_w[i] + 1) % plen[i]) == 0;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < N; i++) dut_hs[i] = 0;
    dut_wr = 0;
    dut_wq.delete();
    dut_gq.delete();
    stall_rdy = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("req_ready", req_ready, exp_ready());
    chk("grant_active", grant_active, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("fifo_wr_en", fifo_wr_en, m_wen);
    chk("fifo_wr_data", fifo_wr_data, m_wdata);
    chk("ovf_err", ovf_err, m_ovf);
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) dut_hs[i]++;
    if (fifo_wr_en) begin
      dut_wr++;
      dut_wq.push_back(fifo_wr_data);
    end
    if (grant_active && !prev_ga) dut_gq.push_back(int'(grant_id));
    prev_ga = grant_active;
    if (fifo_wr_pfull && req_ready != '0) stall_rdy++;
    @(posedge clk);
    model_update();
    #1;
    if (dir_mode) drive_src();
  endtask

  initial begin
    model_reset();
    prev_ga = 0;
    dir_mode = 1;
    for (int i = 0; i < N; i++) begin
      src_w[i] = 0;
      plen[i]  = 0;
    end
    clear_obs();
    drive_src();

    // Reset state
    tick();
    tick();
    chk("rst_wr_data", fifo_wr_data, 0);
    rst_n = 1'b1;

    // Single requester, 3-word packet
    clear_obs();
    plen[0] = 3;
    drive_src();
    arb_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      req_valid = '0;
      req_valid[0] = (src_w[0] < 3);
      tick();
    end
    chk("p1_writes", dut_wr, 3);
    chk("p1_wq_size", dut_wq.size(), 3);
    if (dut_wq.size() == 3) begin
      chk("p1_w0", dut_wq[0], 8'h00);
      chk("p1_w1", dut_wq[1], 8'h01);
      chk("p1_w2", dut_wq[2], 8'h02);
    end
    chk("p1_grants", dut_gq.size(), 1);
    chk("p1_idle", grant_active, 0);

    // All requesters valid, no last: rotation from ptr=1
    clear_obs();
    plen[0] = 0;
    drive_src();
    req_valid = '1;
    repeat (25) tick();
    req_valid = '0;
    repeat (3) tick();
    chk("p2_grants", dut_gq.size(), 5);
    if (dut_gq.size() == 5) begin
      chk("p2_g0", dut_gq[0], 1);
      chk("p2_g1", dut_gq[1], 2);
      chk("p2_g2", dut_gq[2], 3);
      chk("p2_g3", dut_gq[3], 0);
      chk("p2_g4", dut_gq[4], 1);
    end
    chk("p2_hs0", dut_hs[0], 4);
    chk("p2_hs1", dut_hs[1], 8);
    chk("p2_hs2", dut_hs[2], 4);
    chk("p2_hs3", dut_hs[3], 4);
    chk("p2_writes", dut_wr, 20);

    // pfull stall after word 2 for 5 cycles
    clear_obs();
    src_w[0] = 0;
    drive_src();
    req_valid = 4'b0001;
    for (int n = 0; n < 10 && src_w[0] < 2; n++) tick();
    fifo_wr_pfull = 1'b1;
    repeat (5) tick();
    chk("p3_stall_gid", grant_id, 0);
    fifo_wr_pfull = 1'b0;
    for (int n = 0; n < 10 && src_w[0] < 4; n++) tick();
    req_valid = '0;
    repeat (2) tick();
    chk("p3_hs0", dut_hs[0], 4);
    chk("p3_grants", dut_gq.size(), 1);
    chk("p3_stall_rdy", stall_rdy, 0);
    chk("p3_writes", dut_wr, 4);
    chk("p3_released", grant_active, 0);

    // Requester 2 abandons, 3 takes over, then arb_en drops mid-burst
    clear_obs();
    src_w[2] = 0;
    src_w[3] = 0;
    drive_src();
    req_valid = 4'b1100;
    for (int n = 0; n < 10 && src_w[2] < 2; n++) tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    for (int n = 0; n < 10 && src_w[3] < 1; n++) tick();
    arb_en = 1'b0;
    repeat (4) tick();
    chk("p4_grants", dut_gq.size(), 2);
    if (dut_gq.size() == 2) begin
      chk("p4_g0", dut_gq[0], 2);
      chk("p4_g1", dut_gq[1], 3);
    end
    chk("p4_hs2", dut_hs[2], 2);
    chk("p4_hs3", dut_hs[3], 1);
    chk("p4_no_grant", grant_active, 0);
    chk("p4_gid_hold", grant_id, 3);
    arb_en = 1'b1;
    req_valid = '0;
    tick();

    // Overflow: set, set beats clear, clear alone
    clear_obs();
    src_w[1] = 0;
    drive_src();
    req_valid = 4'b0010;
    fifo_wr_full = 1'b1;
    repeat (4) tick();
    chk("ovf_set", ovf_err, 1);
    ovf_clr = 1'b1;
    tick();
    chk("ovf_set_beats_clr", ovf_err, 1);
    fifo_wr_full = 1'b0;
    tick();
    chk("ovf_clr", ovf_err, 0);
    ovf_clr = 1'b0;
    req_valid = '0;
    repeat (2) tick();

    // Reset mid-burst with ptr parked at 1
    clear_obs();
    plen[0] = 1;
    src_w[0] = 0;
    drive_src();
    req_valid = 4'b0001;
    tick();
    tick();
    req_valid = 4'b0010;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant_active", grant_active, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data_mid", fifo_wr_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ovf", ovf_err, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0011;
    tick();
    chk("post_rst_active", grant_active, 1);
    chk("post_rst_gid", grant_id, 0);
    req_valid = '0;
    repeat (2) tick();

    // Random traffic
    dir_mode = 0;
    for (int n = 0; n < 600; n++) begin
      arb_en        = ($urandom_range(0, 9) != 0);
      req_valid     = N'($urandom | $urandom);
      req_last      = N'($urandom);
      req_data      = $urandom;
      fifo_wr_pfull = ($urandom_range(0, 4) == 0);
      fifo_wr_full  = ($urandom_range(0, 9) == 0);
      ovf_clr       = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
